// File: rtl/frost32_mem_responder.sv
// frost32_mem_responder: wait-state memory model for the FROST32 CPU bus with byte-lane writes.
// Define FROST32_MEM_FAULT_IRQ_EN to trap misaligned/bad-size accesses with an interrupt pulse.
module frost32_mem_responder #(
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        access_type,
  input  logic [1:0]  access_size,
  output logic [31:0] data_out,
  output logic        wait_for_mem,
  output logic        interrupt
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic go, fault, unused_addr;
  logic [31:0] mem [2**MEM_DEPTH_LOG2];
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic [1:0] sz;
  logic [3:0] lanes;
  logic [31:0] wdata, word, rdata;
  assign idx = addr[MEM_DEPTH_LOG2+1:2];
  assign unused_addr = ^addr[31:MEM_DEPTH_LOG2+2];
`ifdef FROST32_MEM_FAULT_IRQ_EN
  assign fault = access_size == 2'd3 || (access_size == 2'd0 && addr[1:0] != 2'd0) ||
                 (access_size == 2'd1 && addr[0]);
`else
  assign fault = 1'b0;
`endif
  // Size 3 aliases to a word access; misaligned low bits simply fall out of the lane select.
  assign sz = access_size == 2'd3 ? 2'd0 : access_size;
  assign lanes = sz == 2'd0 ? 4'hf : sz == 2'd1 ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
  assign wdata = sz == 2'd0 ? data_in : sz == 2'd1 ? {2{data_in[15:0]}} : {4{data_in[7:0]}};
  assign word = mem[idx];
  assign rdata = sz == 2'd0 ? word :
                 sz == 2'd1 ? {16'h0, addr[1] ? word[31:16] : word[15:0]} :
                 {24'h0, word[{addr[1:0], 3'b000} +: 8]};
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    go = 1'b0;
    wait_for_mem = state == BUSY;
    if (state == IDLE) begin
      wait_for_mem = req_mem_access;
      if (req_mem_access) begin
        if (WAIT_CYCLES == 0) begin
          go = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = BUSY;
          cnt_nx = 4'(WAIT_CYCLES - 1);
        end
      end
    end else if (state == BUSY) begin
      if (cnt == 4'd0) begin
        go = 1'b1;
        state_nx = DONE;
      end else begin
        cnt_nx = cnt - 4'd1;
      end
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_out <= 32'h0;
      interrupt <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      interrupt <= go && fault;
      if (go && (fault || !access_type)) data_out <= fault ? 32'h0 : rdata;
    end
  end
  // rst_n gates the commit so a zero-wait request held through reset cannot write.
  always_ff @(posedge clk) begin
    if (go && rst_n && access_type && !fault)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_frost32_mem_responder.sv
// tb_frost32_mem_responder: randomized check of frost32_mem_responder against a byte-addressed model.
module tb_frost32_mem_responder;
  logic clk = 1'b0, rst_n = 1'b1;
  logic req = 1'b0, t = 1'b0;
  logic [1:0] sz = 2'd0;
  logic [31:0] addr = 32'h0, din = 32'h0;
  logic [31:0] dout;
  logic wt, irq;
  logic req0 = 1'b0, t0 = 1'b0;
  logic [1:0] sz0 = 2'd0;
  logic [31:0] addr0 = 32'h0, din0 = 32'h0;
  logic [31:0] dout0;
  logic wt0, irq0;
  int checks = 0, errors = 0;
  logic [7:0] mb [4096];
  logic [31:0] exp_do = 32'h0;

  always #5 clk = ~clk;

  frost32_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .req_mem_access(req), .addr(addr), .data_in(din),
    .access_type(t), .access_size(sz), .data_out(dout), .wait_for_mem(wt), .interrupt(irq)
  );

  frost32_mem_responder #(.MEM_DEPTH_LOG2(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_mem_access(req0), .addr(addr0), .data_in(din0),
    .access_type(t0), .access_size(sz0), .data_out(dout0), .wait_for_mem(wt0), .interrupt(irq0)
  );

  function automatic bit is_fault(input logic [1:0] s, input logic [31:0] a);
`ifdef FROST32_MEM_FAULT_IRQ_EN
    return s == 2'd3 || (s == 2'd0 && a[1:0] != 2'd0) || (s == 2'd1 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  // Little-endian byte memory over a 4 KiB window (1024 words); upper address bits alias.
  task automatic model(input bit wr, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, output bit f);
    int n, b;
    f = is_fault(s, a);
    n = (s == 2'd1) ? 2 : (s == 2'd2) ? 1 : 4;
    b = int'(a[11:0]) & ~(n - 1);
    if (f) exp_do = 32'h0;
    else if (wr) for (int k = 0; k < n; k++) mb[b + k] = d[8*k +: 8];
    else begin
      exp_do = 32'h0;
      for (int k = 0; k < n; k++) exp_do[8*k +: 8] = mb[b + k];
    end
  endtask

  task automatic access(input bit wr, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    bit f;
    int n;
    model(wr, s, a, d, f);
    @(negedge clk);
    req = 1'b1; t = wr; sz = s; addr = a; din = d; n = 0;
    #1;
    while (wt && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL %s wait_len got %0d exp 3", nm, n); end
    checks++;
    if (dout !== exp_do) begin errors++; $display("FAIL %s data_out got %h exp %h", nm, dout, exp_do); end
    checks++;
    if (irq !== f) begin errors++; $display("FAIL %s interrupt got %b exp %b", nm, irq, f); end
    req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL %s irq_after got %b exp 0", nm, irq); end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if (dout !== 32'h0 || irq !== 1'b0 || wt !== 1'b0) begin
      errors++; $display("FAIL reset_out got %h %b %b exp 0 0 0", dout, irq, wt);
    end
    req = 1'b1;
    #1;
    checks++;
    if (wt !== 1'b1) begin errors++; $display("FAIL reset_wait_follows got %b exp 1", wt); end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    logic [31:0] prev, e;
    prev = 32'h0;
    for (int i = 0; i < 4; i++) v[i] = $urandom;
    @(negedge clk);
    req0 = 1'b1; t0 = 1'b1; sz0 = 2'd0; addr0 = 32'h0; din0 = v[0];
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (wt0 !== 1'b1) begin errors++; $display("FAIL b2b_accept op %0d wait got %b exp 1", i, wt0); end
      @(negedge clk);
      #1;
      checks++;
      if (wt0 !== 1'b0) begin errors++; $display("FAIL b2b_done op %0d wait got %b exp 0", i, wt0); end
      e = (i % 2 == 1) ? v[i/2] : prev;
      checks++;
      if (dout0 !== e) begin errors++; $display("FAIL b2b_data op %0d got %h exp %h", i, dout0, e); end
      prev = e;
      if (i < 7) begin
        t0 = ((i + 1) % 2 == 0);
        addr0 = 32'((i + 1) / 2 * 4);
        din0 = v[(i + 1) / 2];
      end else req0 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_init();
    for (int w = 0; w < 16; w++) access(1'b1, 2'd0, 32'(w * 4), $urandom, "init");
  endtask

  task automatic test_basic();
    access(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, "wr_deadbeef");
    access(1'b0, 2'd0, 32'h10, 32'h0, "rd_deadbeef");
    checks++;
    if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_const got %h exp deadbeef", dout); end
    access(1'b1, 2'd2, 32'h12, 32'h55, "wr_byte");
    access(1'b0, 2'd0, 32'h10, 32'h0, "rd_merged");
    checks++;
    if (dout !== 32'hDE55BEEF) begin errors++; $display("FAIL merged_const got %h exp de55beef", dout); end
    access(1'b0, 2'd1, 32'h12, 32'h0, "rd_half");
    checks++;
    if (dout !== 32'h0000DE55) begin errors++; $display("FAIL half_const got %h exp 0000de55", dout); end
  endtask

  task automatic test_wrap();
    access(1'b1, 2'd0, 32'h1000, 32'h12345678, "wr_wrap");
    access(1'b0, 2'd0, 32'h0, 32'h0, "rd_wrap");
    checks++;
    if (dout !== 32'h12345678) begin errors++; $display("FAIL wrap_const got %h exp 12345678", dout); end
  endtask

  task automatic test_reset_abort();
    access(1'b1, 2'd0, 32'h20, 32'h0, "abort_clear");
    access(1'b0, 2'd0, 32'h10, 32'h0, "abort_preload");
    @(negedge clk);
    req = 1'b1; t = 1'b1; sz = 2'd0; addr = 32'h20; din = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (wt !== 1'b1) begin errors++; $display("FAIL abort_busy wait got %b exp 1", wt); end
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0 || wt !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got %h %b %b exp 0 0 0", dout, wt, irq);
    end
    exp_do = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 2'd0, 32'h20, 32'h0, "abort_read");
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL abort_const got %h exp 0", dout); end
  endtask

  task automatic test_fault();
    access(1'b1, 2'd0, 32'h21, 32'hA5A5A5A5, "misaligned_wr");
    access(1'b0, 2'd0, 32'h20, 32'h0, "misaligned_rd");
    access(1'b0, 2'd3, 32'h24, 32'h0, "size3_rd");
    access(1'b1, 2'd1, 32'h2B, 32'h0000C3C3, "half_misaligned_wr");
    access(1'b0, 2'd0, 32'h28, 32'h0, "half_misaligned_rd");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom & 32'hFFFFF03F,
             $urandom, "random");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_init();
    test_basic();
    test_wrap();
    test_reset_abort();
    test_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frost32_mem_responder.md
FROST32_MEM_RESPONDER -- requirements
Module: frost32_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of the number of 32-bit words in the internal array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, busy cycles inserted before each access completes (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_mem_access  input  1  CPU requests an access.
REQ-006 SHALL have port addr  input  32  byte address.
REQ-007 SHALL have port data_in  input  32  write data from CPU, right-justified for 16/8-bit sizes.
REQ-008 SHALL have port access_type  input  1  0=read (DiatRead), 1=write (DiatWrite).
REQ-009 SHALL have port access_size  input  2  0=32-bit, 1=16-bit, 2=8-bit, 3=bad (Dias encoding).
REQ-010 SHALL have port data_out  output  32  read data to CPU, zero-extended.
REQ-011 SHALL have port wait_for_mem  output  1  CPU must stall and hold request signals stable while high.
REQ-012 SHALL have port interrupt  output  1  access-fault pulse (see Configuration).

Function
REQ-013 SHALL implement FSM states Idle, Busy, Done; 4-bit down-counter cnt.
REQ-014 In Idle, wait_for_mem SHALL equal req_mem_access combinationally; all other states wait_for_mem = (state==Busy).
REQ-015 Idle with req high: WAIT_CYCLES>0 -> Busy, cnt=WAIT_CYCLES-1; WAIT_CYCLES=0 -> perform access, go Done.
REQ-016 Busy: cnt>0 -> decrement; cnt==0 -> perform access on that edge, go Done.
REQ-017 Request at edge-cycle 0 SHALL see wait_for_mem low (Done) in cycle WAIT_CYCLES+1; data_out valid in that cycle.
REQ-018 Done SHALL last exactly one cycle, ignore req_mem_access, then return to Idle; next request accepted in the following cycle.
REQ-019 Word index SHALL be addr[MEM_DEPTH_LOG2+1:2]; upper address bits ignored (wrap-around).
REQ-020 Read 32: data_out=word; 16: halfword selected by addr[1], bits 31:16 zero; 8: byte selected by addr[1:0], bits 31:8 zero.
REQ-021 Write SHALL update only the addressed byte lanes (4, 2 or 1) from data_in low bits; other bytes unchanged.
REQ-022 Write SHALL leave data_out at its previous value.
REQ-023 Inputs SHALL be sampled at the access edge only; changes while Busy are a CPU protocol error, not checked.

Reset
REQ-024 rst_n low SHALL immediately force state=Idle, cnt=0, data_out=0, interrupt=0; wait_for_mem then follows REQ-014.
REQ-025 Reset during Busy SHALL abort the access; a pending write SHALL NOT be committed.
REQ-026 Array contents SHALL NOT be reset.

Configuration
REQ-027 Macro FROST32_MEM_FAULT_IRQ_EN SHALL select fault handling.
REQ-028 Defined: fault = size 3, or 32-bit with addr[1:0]!=0, or 16-bit with addr[0]!=0; faulting access SHALL NOT modify the array, SHALL set data_out=0, and interrupt SHALL be high for exactly the Done cycle.
REQ-029 Undefined: interrupt tied 0; size 3 treated as 32-bit; misaligned low address bits ignored (32-bit: addr[1:0] forced 0; 16-bit: addr[0] forced 0).

Verification
REQ-030 WAIT_CYCLES=2: write 32-bit 0xDEADBEEF @0x10, then read 32 @0x10 -> wait_for_mem high 3 cycles each, data_out=0xDEADBEEF in Done.
REQ-031 After REQ-030: write 8-bit 0x55 @0x12, read 32 @0x10 -> 0xDE55BEEF; read 16 @0x12 -> 0x0000DE55.
REQ-032 MEM_DEPTH_LOG2=10: write 0x12345678 @0x1000, read @0x0000 -> 0x12345678 (wrap).
REQ-033 WAIT_CYCLES=0: back-to-back reads -> wait_for_mem high 1 cycle, Done next, new request accepted cycle after Done.
REQ-034 rst_n low in 2nd Busy cycle of write 0xFFFFFFFF @0x20 (prior 0x0) -> outputs 0 immediately; later read @0x20 -> 0x00000000.
REQ-035 With FROST32_MEM_FAULT_IRQ_EN: write 32 @0x21 -> interrupt high 1 cycle, array unchanged; size 3 read -> data_out=0, interrupt pulse; without macro: write 32 @0x21 of 0xA5A5A5A5, read @0x20 -> 0xA5A5A5A5, interrupt stays 0.
